// File: rtl/fp_multiplier.sv
// Iterative IEEE-style multiplier: shift-add significands, then normalise/round/flag. Optional RNE via FP_MULTIPLIER_RNE_EN.
// Latency: start sampled in cycle 0, mul_done from cycle MAN_W+3; truncation when FP_MULTIPLIER_RNE_EN is undefined.
// Backpressure: result held in DONE until mul_serv; mul_start outside IDLE is dropped, no queueing.
module fp_multiplier #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   mul_start,
    input  logic                   mul_serv,
    input  logic [EXP_W+MAN_W:0]   op1,
    input  logic [EXP_W+MAN_W:0]   op2,
    output logic [EXP_W+MAN_W:0]   mul_result,
    output logic                   mul_done,
    output logic                   mul_busy,
    output logic                   mul_overflow,
    output logic                   mul_underflow
);
    localparam int W      = 1 + EXP_W + MAN_W;
    localparam int SIG_W  = MAN_W + 1;
    localparam int PROD_W = 2 * SIG_W;
    localparam int EW     = EXP_W + 2;
    localparam int CNT_W  = $clog2(SIG_W + 1);
    localparam int BIAS   = (1 << (EXP_W - 1)) - 1;
    localparam int EMAX   = (1 << EXP_W) - 1;

    typedef enum logic [1:0] {IDLE, MULT, NORM, DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PROD_W-1:0]   mcand_q, mcand_d;
    logic [SIG_W-1:0]    mplier_q, mplier_d;
    logic [PROD_W-1:0]   acc_q, acc_d;
    logic                sign_q, sign_d;
    logic [EXP_W-1:0]    ea_q, ea_d;
    logic [EXP_W-1:0]    eb_q, eb_d;
    logic [W-1:0]        res_q, res_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;

    logic [EW-1:0]       norm_e;
    logic [MAN_W-1:0]    norm_mant;
    logic [W-1:0]        norm_res;
    logic                norm_ovf;
    logic                norm_unf;
`ifdef FP_MULTIPLIER_RNE_EN
    logic                rnd_guard;
    logic                rnd_sticky;
    logic [MAN_W:0]      rnd_sum;
`endif

    // Exponent is carried in EW bits as two's complement so underflow shows up as a set MSB.
    always_comb begin
        norm_e    = EW'(ea_q) + EW'(eb_q) - EW'(BIAS) + EW'(acc_q[PROD_W-1]);
        norm_mant = acc_q[PROD_W-1] ? acc_q[PROD_W-2 -: MAN_W] : acc_q[PROD_W-3 -: MAN_W];
`ifdef FP_MULTIPLIER_RNE_EN
        rnd_guard  = acc_q[PROD_W-1] ? acc_q[MAN_W] : acc_q[MAN_W-1];
        rnd_sticky = acc_q[PROD_W-1] ? (|acc_q[MAN_W-1:0]) : (|acc_q[MAN_W-2:0]);
        rnd_sum    = {1'b0, norm_mant}
                   + {{MAN_W{1'b0}}, rnd_guard & (rnd_sticky | norm_mant[0])};
        // All-ones mantissa rounding up lands on 2.0: mantissa wraps to zero, exponent bumps.
        if (rnd_sum[MAN_W]) begin
            norm_e = norm_e + EW'(1);
        end
        norm_mant = rnd_sum[MAN_W-1:0];
`endif
        norm_res = {sign_q, norm_e[EXP_W-1:0], norm_mant};
        norm_ovf = 1'b0;
        norm_unf = 1'b0;
        if (ea_q == {EXP_W{1'b1}} || eb_q == {EXP_W{1'b1}}) begin
            norm_res = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            norm_ovf = 1'b1;
        end else if (ea_q == '0 || eb_q == '0) begin
            norm_res = {sign_q, {(W-1){1'b0}}};
        end else if (!norm_e[EW-1] && norm_e >= EW'(EMAX)) begin
            norm_res = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            norm_ovf = 1'b1;
        end else if (norm_e[EW-1] || norm_e == '0) begin
            norm_res = {sign_q, {(W-1){1'b0}}};
            norm_unf = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        sign_d   = sign_q;
        ea_d     = ea_q;
        eb_d     = eb_q;
        res_d    = res_q;
        done_d   = done_q;
        busy_d   = busy_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        case (state_q)
            IDLE: begin
                if (mul_start) begin
                    sign_d   = op1[W-1] ^ op2[W-1];
                    ea_d     = op1[W-2 -: EXP_W];
                    eb_d     = op2[W-2 -: EXP_W];
                    mcand_d  = {{SIG_W{1'b0}}, 1'b1, op1[MAN_W-1:0]};
                    mplier_d = {1'b1, op2[MAN_W-1:0]};
                    acc_d    = '0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = MULT;
                end
            end
            MULT: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(MAN_W)) begin
                    state_d = NORM;
                end
            end
            NORM: begin
                res_d   = norm_res;
                ovf_d   = norm_ovf;
                unf_d   = norm_unf;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (mul_serv) begin
                    done_d  = 1'b0;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            sign_q   <= 1'b0;
            ea_q     <= '0;
            eb_q     <= '0;
            res_q    <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            sign_q   <= sign_d;
            ea_q     <= ea_d;
            eb_q     <= eb_d;
            res_q    <= res_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign mul_result    = res_q;
    assign mul_done      = done_q;
    assign mul_busy      = busy_q;
    assign mul_overflow  = ovf_q;
    assign mul_underflow = unf_q;
endmodule

// File: tb/tb_fp_multiplier.sv
// Scoreboard bench for fp_multiplier at single-precision defaults; inputs driven and outputs sampled on the falling edge.
module tb_fp_multiplier;
    logic        clk = 1'b0;
    logic        n_rst;
    logic        mul_start;
    logic        mul_serv;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] mul_result;
    logic        mul_done;
    logic        mul_busy;
    logic        mul_overflow;
    logic        mul_underflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t sb[$];

    fp_multiplier #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk),
        .n_rst(n_rst),
        .mul_start(mul_start),
        .mul_serv(mul_serv),
        .op1(op1),
        .op2(op2),
        .mul_result(mul_result),
        .mul_done(mul_done),
        .mul_busy(mul_busy),
        .mul_overflow(mul_overflow),
        .mul_underflow(mul_underflow)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t        r;
        logic        s;
        logic [63:0] p;
        logic [22:0] m;
        logic [23:0] rem;
        logic [23:0] half;
        int          e;
        s = a[31] ^ b[31];
        r.ovf = 1'b0;
        r.unf = 1'b0;
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
            r.res = {s, 8'hFF, 23'd0};
            r.ovf = 1'b1;
            return r;
        end
        if (a[30:23] == 8'h00 || b[30:23] == 8'h00) begin
            r.res = {s, 31'd0};
            return r;
        end
        p = {40'd0, 1'b1, a[22:0]} * {40'd0, 1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            e++;
            m = p[46:24];
            rem = p[23:0];
            half = 24'h800000;
        end else begin
            m = p[45:23];
            rem = {1'b0, p[22:0]};
            half = 24'h400000;
        end
`ifdef FP_MULTIPLIER_RNE_EN
        if (rem > half || (rem == half && m[0])) begin
            if (m == 23'h7FFFFF) begin
                m = 23'd0;
                e++;
            end else begin
                m = m + 23'd1;
            end
        end
`else
        if (rem > half) m = m;
`endif
        if (e >= 255) begin
            r.res = {s, 8'hFF, 23'd0};
            r.ovf = 1'b1;
        end else if (e <= 0) begin
            r.res = {s, 31'd0};
            r.unf = 1'b1;
        end else begin
            r.res = {s, e[7:0], m};
        end
        return r;
    endfunction

    task automatic launch(input logic [31:0] a, input logic [31:0] b, input bit push, input exp_t ex);
        op1 = a;
        op2 = b;
        mul_start = 1'b1;
        if (push) sb.push_back(ex);
        @(negedge clk);
        mul_start = 1'b0;
    endtask

    // Called in cycle c0; returns the cycle in which mul_done was first seen and how many busy cycles were seen.
    task automatic wait_done(input int c0, output int lat, output int busy_n);
        lat = c0;
        busy_n = 0;
        while (!mul_done && lat < 100) begin
            if (mul_busy) busy_n++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic serve();
        mul_serv = 1'b1;
        @(negedge clk);
        mul_serv = 1'b0;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        mul_start = 1'b0;
        mul_serv = 1'b0;
        op1 = '0;
        op2 = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({mul_result, mul_done, mul_busy, mul_overflow, mul_underflow} !== 36'd0) begin
            errors++;
            $display("FAIL reset_outputs got res=%h done=%b busy=%b ovf=%b unf=%b want all 0",
                     mul_result, mul_done, mul_busy, mul_overflow, mul_underflow);
        end
        n_rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        exp_t ex;
        exp_t got;
        int lat;
        int bn;
        ex = '{32'h40400000, 1'b0, 1'b0};
        launch(32'h3FC00000, 32'h40000000, 1, ex);
        wait_done(1, lat, bn);
        got = sb.pop_front();
        checks++;
        if (lat !== 26) begin errors++; $display("FAIL basic_latency got %0d want 26", lat); end
        checks++;
        if (bn !== 25) begin errors++; $display("FAIL basic_busy_cycles got %0d want 25", bn); end
        checks++;
        if ({mul_result, mul_overflow, mul_underflow} !== {got.res, got.ovf, got.unf}) begin
            errors++;
            $display("FAIL basic_result got %h/%b%b want %h/%b%b", mul_result, mul_overflow, mul_underflow,
                     got.res, got.ovf, got.unf);
        end
        checks++;
        if (mul_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_in_done got %b want 0", mul_busy); end
        serve();
        checks++;
        if ({mul_done, mul_busy} !== 2'b00) begin
            errors++;
            $display("FAIL basic_serve got done=%b busy=%b want 0 0", mul_done, mul_busy);
        end
    endtask

    task automatic test_hold();
        exp_t ex;
        exp_t got;
        int lat;
        int bn;
        ex = '{32'hC0C00000, 1'b0, 1'b0};
        launch(32'hC0000000, 32'h40400000, 1, ex);
        wait_done(1, lat, bn);
        got = sb.pop_front();
        checks++;
        if (lat !== 26) begin errors++; $display("FAIL hold_latency got %0d want 26", lat); end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({mul_done, mul_result} !== {1'b1, got.res}) begin
                errors++;
                $display("FAIL hold_stable cycle %0d got done=%b res=%h want 1 %h", i, mul_done, mul_result, got.res);
            end
            @(negedge clk);
        end
        serve();
        checks++;
        if (mul_done !== 1'b0) begin errors++; $display("FAIL hold_release got done=%b want 0", mul_done); end
    endtask

    task automatic test_flags();
        logic [31:0] va[12];
        logic [31:0] vb[12];
        exp_t        ve[12];
        exp_t        got;
        int          lat;
        int          bn;
        va[0] = 32'h7F000000; vb[0] = 32'h7F000000; ve[0] = '{32'h7F800000, 1'b1, 1'b0};
        va[1] = 32'h00800000; vb[1] = 32'h00800000; ve[1] = '{32'h00000000, 1'b0, 1'b1};
        va[2] = 32'h7F800000; vb[2] = 32'hBF800000; ve[2] = '{32'hFF800000, 1'b1, 1'b0};
        va[3] = 32'h00000000; vb[3] = 32'hBF800000; ve[3] = '{32'h80000000, 1'b0, 1'b0};
        va[4] = 32'h7F800000; vb[4] = 32'h00000000; ve[4] = '{32'h7F800000, 1'b1, 1'b0};
        va[5] = 32'hFF000000; vb[5] = 32'h7F000000; ve[5] = '{32'hFF800000, 1'b1, 1'b0};
        va[6] = 32'h80800000; vb[6] = 32'h00800000; ve[6] = '{32'h80000000, 1'b0, 1'b1};
        va[7] = 32'h7F000000; vb[7] = 32'h3F800000; ve[7] = '{32'h7F000000, 1'b0, 1'b0};
        va[8] = 32'h7F000000; vb[8] = 32'h40000000; ve[8] = '{32'h7F800000, 1'b1, 1'b0};
        va[9] = 32'h00800000; vb[9] = 32'h3F800000; ve[9] = '{32'h00800000, 1'b0, 1'b0};
        va[10] = 32'h00800000; vb[10] = 32'h3F000000; ve[10] = '{32'h00000000, 1'b0, 1'b1};
`ifdef FP_MULTIPLIER_RNE_EN
        va[11] = 32'h3FC00001; vb[11] = 32'h3FC00001; ve[11] = '{32'h40100002, 1'b0, 1'b0};
`else
        va[11] = 32'h3FC00001; vb[11] = 32'h3FC00001; ve[11] = '{32'h40100001, 1'b0, 1'b0};
`endif
        for (int i = 0; i < 12; i++) begin
            launch(va[i], vb[i], 1, ve[i]);
            wait_done(1, lat, bn);
            got = sb.pop_front();
            checks++;
            if (lat !== 26 || {mul_result, mul_overflow, mul_underflow} !== {got.res, got.ovf, got.unf}) begin
                errors++;
                $display("FAIL flags_vec%0d %h*%h got %h/%b%b lat %0d want %h/%b%b lat 26", i, va[i], vb[i],
                         mul_result, mul_overflow, mul_underflow, lat, got.res, got.ovf, got.unf);
            end
            serve();
            checks++;
            if ({mul_done, mul_overflow, mul_underflow} !== 3'b000) begin
                errors++;
                $display("FAIL flags_clear%0d got done=%b ovf=%b unf=%b want 0 0 0", i, mul_done, mul_overflow, mul_underflow);
            end
        end
    endtask

    task automatic test_abort();
        exp_t ex;
        exp_t got;
        int lat;
        int bn;
        ex = '{32'h0, 1'b0, 1'b0};
        launch(32'h40000000, 32'h40000000, 0, ex);
        repeat (9) @(negedge clk);
        n_rst = 1'b0;
        #1;
        checks++;
        if ({mul_result, mul_done, mul_busy, mul_overflow, mul_underflow} !== 36'd0) begin
            errors++;
            $display("FAIL abort_outputs got res=%h done=%b busy=%b want all 0", mul_result, mul_done, mul_busy);
        end
        @(negedge clk);
        n_rst = 1'b1;
        ex = '{32'h3F800000, 1'b0, 1'b0};
        launch(32'h3F800000, 32'h3F800000, 1, ex);
        wait_done(1, lat, bn);
        got = sb.pop_front();
        checks++;
        if (lat !== 26 || mul_result !== got.res) begin
            errors++;
            $display("FAIL abort_restart got %h lat %0d want %h lat 26", mul_result, lat, got.res);
        end
        serve();
    endtask

    task automatic test_ignore();
        exp_t ex;
        exp_t got;
        int lat;
        int bn;
        ex = '{32'h40400000, 1'b0, 1'b0};
        launch(32'h3FC00000, 32'h40000000, 1, ex);
        repeat (4) @(negedge clk);
        op1 = 32'h7F000000;
        op2 = 32'h7F000000;
        mul_start = 1'b1;
        @(negedge clk);
        mul_start = 1'b0;
        wait_done(6, lat, bn);
        got = sb.pop_front();
        checks++;
        if (lat !== 26 || {mul_result, mul_overflow} !== {got.res, got.ovf}) begin
            errors++;
            $display("FAIL ignore_mult got %h ovf=%b lat %0d want %h ovf=%b lat 26", mul_result, mul_overflow, lat,
                     got.res, got.ovf);
        end
        op1 = 32'h3F800000;
        op2 = 32'h3F800000;
        mul_start = 1'b1;
        serve();
        mul_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({mul_done, mul_busy} !== 2'b00) begin
                errors++;
                $display("FAIL ignore_serve cycle %0d got done=%b busy=%b want 0 0", i, mul_done, mul_busy);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        exp_t got;
        int lat;
        int bn;
        for (int i = 0; i < 10; i++) begin
            a = {1'($urandom), 8'($urandom_range(64, 190)), 23'($urandom)};
            b = {1'($urandom), 8'($urandom_range(64, 190)), 23'($urandom)};
            if (i == 0) a[22:0] = 23'h7FFFFF;
            if (i == 0) b = 32'h3F800001;
            launch(a, b, 1, model(a, b));
            wait_done(1, lat, bn);
            got = sb.pop_front();
            checks++;
            if (lat !== 26 || {mul_result, mul_overflow, mul_underflow} !== {got.res, got.ovf, got.unf}) begin
                errors++;
                $display("FAIL random%0d %h*%h got %h/%b%b lat %0d want %h/%b%b", i, a, b, mul_result,
                         mul_overflow, mul_underflow, lat, got.res, got.ovf, got.unf);
            end
            serve();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_flags();
        test_abort();
        test_ignore();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
